stepper_sequencer: RTL and testbench

Memory-mapped stepper-motor sequencer for the JA header. It accepts a move command (step count, direction, step mode, step period) from the processor's IO path and drives the four coil lines on JA through a half-step phase table, one phase change per programmed period. It exposes busy, done and remaining-step status so software can poll or abort a move. The coil phase is position state: it persists across commands and is cleared only by reset.

---
 rtl/stepper_sequencer.sv | 70 +++++++
 tb/tb_stepper_sequencer.sv | 132 +++++++++++++
 2 files changed

// File: rtl/stepper_sequencer.sv
// stepper_sequencer: memory-mapped half/full-step coil sequencer with abortable moves and status.
module stepper_sequencer #(
  parameter int MIN_PERIOD = 1000,
  parameter int PERIOD_W = 24,
  parameter int STEPS_W = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [STEPS_W-1:0]  cmd_steps,
  input  logic                cmd_dir,
  input  logic                cmd_half,
  input  logic [PERIOD_W-1:0] cmd_period,
  input  logic                abort,
  output logic [3:0]          coils,
  output logic                coil_en,
  output logic                busy,
  output logic                done,
  output logic [STEPS_W-1:0]  steps_left,
  output logic [2:0]          phase
);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  localparam logic [PERIOD_W-1:0] MIN_P = PERIOD_W'(MIN_PERIOD);
  // packed coil table, entry i in bits [4i+3:4i]
  localparam logic [31:0] TBL = 32'h913264C8;
  state_t state;
  logic [PERIOD_W-1:0] cnt, period;
  logic dir, half;
  logic step_edge;
  logic [2:0] delta;
  assign step_edge = cnt == period - 1'b1;
  assign delta = half ? 3'd1 : 3'd2;
  assign cmd_ready = state == IDLE;
  assign busy = !cmd_ready;
  assign done = state == FIN;
  assign coil_en = busy;
  assign coils = coil_en ? TBL[{phase, 2'b00} +: 4] : 4'b0000;
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      phase <= '0;
      cnt <= '0;
      steps_left <= '0;
      dir <= 1'b0;
      half <= 1'b0;
      period <= MIN_P;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          dir <= cmd_dir;
          half <= cmd_half;
          period <= cmd_period < MIN_P ? MIN_P : cmd_period;
          steps_left <= cmd_steps;
          cnt <= '0;
          state <= cmd_steps == '0 ? FIN : RUN;
        end
        // abort outranks a coincident step edge
        RUN: if (abort) state <= FIN;
        else if (step_edge) begin
          cnt <= '0;
          phase <= dir ? phase + delta : phase - delta;
          steps_left <= steps_left - 1'b1;
          if (steps_left == 1) state <= FIN;
        end else cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_stepper_sequencer.sv
// tb_stepper_sequencer: directed moves with a cycle-stamped expectation queue for stepper_sequencer.
module tb_stepper_sequencer;
  logic clock = 0, reset = 1, cmd_valid = 0, cmd_dir = 0, cmd_half = 0, abort = 0;
  logic [15:0] cmd_steps = 0;
  logic [23:0] cmd_period = 0;
  logic cmd_ready, coil_en, busy, done;
  logic [3:0] coils;
  logic [15:0] steps_left;
  logic [2:0] phase;
  int vectors = 0, miscompares = 0, off = 0;
  typedef struct {int at; logic [2:0] ph; logic [15:0] sl; logic dn, bz, ab, cv;} exp_t;
  exp_t q[$];
  exp_t e;
  logic [2:0] m_ph = 0;
  logic [15:0] m_sl = 0;
  int m_n, m_p;
  logic m_dir, m_half;

  stepper_sequencer #(.MIN_PERIOD(4), .PERIOD_W(24), .STEPS_W(16)) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_steps(cmd_steps), .cmd_dir(cmd_dir), .cmd_half(cmd_half), .cmd_period(cmd_period),
    .abort(abort), .coils(coils), .coil_en(coil_en), .busy(busy), .done(done),
    .steps_left(steps_left), .phase(phase)
  );

  always #5 clock = ~clock;

  function automatic logic [3:0] tbl(input logic [2:0] p);
    case (p)
      3'd0: return 4'b1000;
      3'd1: return 4'b1100;
      3'd2: return 4'b0100;
      3'd3: return 4'b0110;
      3'd4: return 4'b0010;
      3'd5: return 4'b0011;
      3'd6: return 4'b0001;
      default: return 4'b1001;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s @off %0d: observed %0h expected %0h", tag, off, obs, exp);
    end
  endtask

  task automatic check_now(input logic [2:0] ph, input logic [15:0] sl, input logic dn, input logic bz);
    chk("phase", 32'(phase), 32'(ph));
    chk("coils", 32'(coils), 32'(bz ? tbl(ph) : 4'b0000));
    chk("steps_left", 32'(steps_left), 32'(sl));
    chk("done", 32'(done), 32'(dn));
    chk("busy", 32'(busy), 32'(bz));
    chk("coil_en", 32'(coil_en), 32'(bz));
    chk("cmd_ready", 32'(cmd_ready), 32'(!bz));
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
    off += n;
  endtask

  task automatic push(input int at, input logic dn, input logic bz, input logic ab, input logic cv);
    q.push_back('{at, m_ph, m_sl, dn, bz, ab, cv});
  endtask

  task automatic send(input int n, input logic d, input logic h, input int p);
    chk("ready_before_cmd", 32'(cmd_ready), 32'd1);
    cmd_steps = 16'(n); cmd_dir = d; cmd_half = h; cmd_period = 24'(p); cmd_valid = 1;
    m_n = n; m_dir = d; m_half = h; m_p = p < 4 ? 4 : p; m_sl = 16'(n);
    off = 0;
    tick(1);
    cmd_valid = 0;
    push(1, n == 0, 1, 0, 0);
  endtask

  task automatic plan_steps(input int from, input int upto);
    for (int n = from; n <= upto; n++) begin
      push(n * m_p, 0, 1, 0, 0);
      m_ph = m_dir ? m_ph + (m_half ? 3'd1 : 3'd2) : m_ph - (m_half ? 3'd1 : 3'd2);
      m_sl--;
      push(n * m_p + 1, n == m_n, 1, 0, 0);
    end
    if (upto == m_n) push(m_n * m_p + 2, 0, 0, 0, 0);
  endtask

  task automatic drain();
    while (q.size() > 0) begin
      e = q.pop_front();
      tick(e.at - off);
      check_now(e.ph, e.sl, e.dn, e.bz);
      abort = e.ab;
      cmd_valid = e.cv;
      if (e.cv) cmd_steps = 16'd99;
    end
  endtask

  initial begin
    repeat (3) @(negedge clock);
    reset = 0;
    check_now(0, 0, 0, 0);
    // half-step forward 1,2,3; done at +13, ready at +14
    send(3, 1, 1, 4); plan_steps(1, 3); drain();
    // bring phase to 1, then full-step reverse through the wrap: 7, 5
    send(2, 0, 1, 4); plan_steps(1, 2); drain();
    send(2, 0, 0, 5); plan_steps(1, 2); drain();
    // period 1 clamps to 4
    send(2, 1, 1, 1); plan_steps(1, 2); drain();
    // zero-step command: one-cycle done and coil_en
    send(0, 1, 1, 4); plan_steps(1, 0); drain();
    // abort coinciding with the third step edge
    send(10, 1, 1, 4); plan_steps(1, 2);
    push(12, 0, 1, 1, 0); push(13, 1, 1, 0, 0); push(14, 0, 0, 0, 0);
    drain();
    // command during RUN is ignored
    send(3, 1, 0, 4);
    push(2, 0, 1, 0, 1); push(3, 0, 1, 0, 0);
    plan_steps(1, 3); drain();
    // reset mid-move after reaching phase 5
    send(3, 0, 0, 4); plan_steps(1, 1); drain();
    chk("phase_before_reset", 32'(phase), 32'd5);
    reset = 1;
    tick(1);
    reset = 0;
    check_now(0, 0, 0, 0);
    tick(1);
    check_now(0, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
